// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI register-file slave.
// The state enum, read-command encoding and bit-counter sizing live here.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic CMD_RD = 1'b1;

    // Wide enough to count the longer of the command and data phases, plus one spare bit
    function automatic int bit_cnt_width(input int cmd_bits, input int data_bits);
        int longest;
        longest = (cmd_bits > data_bits) ? cmd_bits : data_bits;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings one asynchronous pad signal into the clk domain.
// It is followed by an edge-detect flop that gives single-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{INIT}};
            prev <= INIT;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = sync[STAGES-1] & ~prev;
    assign fall  = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI mode 0/3 slave fronting a 2**ADDR_W x DATA_W register file.
// Define SPI_MEM_SLAVE_BURST_EN to keep streaming consecutive words until cs_n rises.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              busy,
    output logic              xfer_done,
    output logic              xfer_wr,
    output logic [ADDR_W-1:0] xfer_addr
);

`ifdef SPI_MEM_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int              CNT_W     = bit_cnt_width(1 + ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   cmd_sr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   rx_sr;
    logic [DATA_W-1:0]   tx_sr;
    logic                wr_pend;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [ADDR_W:0]     cmd_full;
    logic [DATA_W:0]     rx_full;
    logic [ADDR_W-1:0]   addr_next;

    assign cmd_full  = {cmd_sr, mosi_level};
    assign rx_full   = {rx_sr, mosi_level};
    assign addr_next = addr + ADDR_W'(1);

    // The write lands one clk after the last data bit, so a cs_n rise racing it cannot drop it
    always_ff @(posedge clk) begin
        if (wr_pend) begin
            mem[addr] <= rx_sr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            addr        <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            wr_pend     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_wr     <= 1'b0;
            xfer_addr   <= '0;
        end else begin
            xfer_done <= 1'b0;
            if (wr_pend) begin
                wr_pend   <= 1'b0;
                xfer_done <= 1'b1;
                xfer_wr   <= 1'b1;
                xfer_addr <= addr;
                if (BURST) begin
                    addr <= addr_next;
                end
            end

            if (cs_rise) begin
                state       <= IDLE;
                busy        <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                bit_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr <= cmd_full[ADDR_W-1:0];
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                addr    <= cmd_full[ADDR_W-1:0];
                                if (cmd_full[ADDR_W] == CMD_RD) begin
                                    tx_sr       <= mem[cmd_full[ADDR_W-1:0]];
                                    spi_miso_oe <= 1'b1;
                                    state       <= READ;
                                end else begin
                                    state <= WRITE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    READ: begin
                        if (sclk_fall) begin
                            spi_miso <= tx_sr[DATA_W-1];
                            tx_sr    <= tx_sr << 1;
                        end
                        if (sclk_rise) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt   <= '0;
                                xfer_done <= 1'b1;
                                xfer_wr   <= 1'b0;
                                xfer_addr <= addr;
                                if (BURST) begin
                                    addr  <= addr_next;
                                    tx_sr <= mem[addr_next];
                                end else begin
                                    state       <= DONE;
                                    spi_miso    <= 1'b0;
                                    spi_miso_oe <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WRITE: begin
                        if (sclk_rise) begin
                            rx_sr <= rx_full[DATA_W-1:0];
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                wr_pend <= 1'b1;
                                if (!BURST) begin
                                    state <= DONE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        spi_miso_oe <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: directed frames plus a randomised write/read loop.
// Expected memory contents and completion tags come from a word-level model of the register file.
module tb_spi_mem_slave;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int HALF   = 80;

`ifdef SPI_MEM_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spi_sclk = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              busy;
    logic              xfer_done;
    logic              xfer_wr;
    logic [ADDR_W-1:0] xfer_addr;

    always #5 clk = ~clk;

    spi_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .busy(busy), .xfer_done(xfer_done), .xfer_wr(xfer_wr), .xfer_addr(xfer_addr)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] model_mem [128];
    bit         model_ok  [128];
    logic [7:0] tx_words[$];
    logic [7:0] rx_words[$];
    logic [7:0] done_q[$];

    // Every completion pulse is logged as {wr, addr} for comparison against the model
    always @(negedge clk) begin
        if (rst_n && xfer_done) done_q.push_back({xfer_wr, xfer_addr});
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one mode-0 frame: command, then nbits data bits from tx_words; collects MISO words
    task automatic applyStimulus(input bit rd, input logic [6:0] a, input int nbits, input int rst_bit);
        logic [7:0] cmd;
        logic [7:0] cur;
        int         oe_err;
        int         nxt;
        int         w;
        bit         exp_oe;
        cmd    = {rd, a};
        cur    = '0;
        oe_err = 0;
        rx_words.delete();
        done_q.delete();
        @(negedge clk);
        spi_cs_n = 1'b0;
        spi_mosi = cmd[7];
        #(HALF);
        for (int i = 0; i < 8 + nbits; i++) begin
            if (i >= 8) begin
                if ((i - 8) == rst_bit) begin
                    rst_n    = 1'b0;
                    spi_cs_n = 1'b1;
                    #1;
                    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                    checkOutput("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
                    spi_sclk = 1'b0;
                    #(4 * HALF);
                    rst_n = 1'b1;
                    #(HALF);
                    return;
                end
                exp_oe = rd && (BURST || (i - 8) < 8);
                cur = {cur[6:0], spi_miso};
                if (rd && ((i - 8) % 8 == 7)) rx_words.push_back(cur);
            end else begin
                exp_oe = 1'b0;
            end
            if (spi_miso_oe !== exp_oe) oe_err++;
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
            nxt = i + 1;
            if (nxt < 8) begin
                spi_mosi = cmd[7 - nxt];
            end else begin
                w = (nxt - 8) / 8;
                spi_mosi = (!rd && w < tx_words.size()) ? tx_words[w][7 - ((nxt - 8) % 8)] : 1'b0;
            end
            #(HALF);
        end
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("oe_profile", oe_err, 0);
    endtask

    // Applies the frame to the model and compares completions, read data and idle outputs
    task automatic checkFrame(input bit rd, input logic [6:0] a, input int nbits);
        int         nw;
        logic [6:0] wa;
        nw = nbits / 8;
        if (!BURST && nw > 1) nw = 1;
        checkOutput("done_count", done_q.size(), nw);
        if (rd) checkOutput("rd_words", rx_words.size(), nbits / 8);
        for (int w = 0; w < nw; w++) begin
            wa = a + 7'(w);
            if (w < done_q.size()) checkOutput("done_tag", {24'd0, done_q[w]}, {24'd0, ~rd, wa});
            if (rd) begin
                if (model_ok[wa] && w < rx_words.size())
                    checkOutput("rd_data", {24'd0, rx_words[w]}, {24'd0, model_mem[wa]});
            end else begin
                model_mem[wa] = tx_words[w];
                model_ok[wa]  = 1'b1;
            end
        end
        if (nw > 0) checkOutput("xfer_addr_hold", {25'd0, xfer_addr}, {25'd0, a + 7'(nw - 1)});
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_oe", {31'd0, spi_miso_oe}, 32'd0);
    endtask

    task automatic writeWords(input logic [6:0] a, input int nbits);
        applyStimulus(1'b0, a, nbits, -1);
        checkFrame(1'b0, a, nbits);
    endtask

    task automatic readWords(input logic [6:0] a, input int nbits);
        applyStimulus(1'b1, a, nbits, -1);
        checkFrame(1'b1, a, nbits);
    endtask

    logic [6:0] ra;
    int         rbits;

    initial begin
        for (int i = 0; i < 128; i++) model_ok[i] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_oe", {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("reset_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("reset_done", {31'd0, xfer_done}, 32'd0);
        checkOutput("reset_wr", {31'd0, xfer_wr}, 32'd0);
        checkOutput("reset_addr", {25'd0, xfer_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] write 0xA5 to 0x05 then read back");
        tx_words = '{8'hA5};
        writeWords(7'h05, 8);
        readWords(7'h05, 8);

        $display("[TB] top address 0x7F");
        tx_words = '{8'h3C};
        writeWords(7'h7F, 8);
        readWords(7'h7F, 8);

        $display("[TB] aborted write keeps prior value");
        tx_words = '{8'h5A};
        writeWords(7'h10, 8);
        tx_words = '{8'hFF};
        writeWords(7'h10, 5);
        readWords(7'h10, 8);

        $display("[TB] reset during read bit 3");
        applyStimulus(1'b1, 7'h05, 8, 3);
        checkOutput("rst_no_done", done_q.size(), 0);
        readWords(7'h05, 8);

        $display("[TB] two words in one write frame");
        tx_words = '{8'h77};
        writeWords(7'h31, 8);
        tx_words = '{8'h11, 8'h22};
        writeWords(7'h30, 16);
        readWords(7'h30, 8);
        readWords(7'h31, 8);

        $display("[TB] two words across the address wrap");
        tx_words = '{8'h11, 8'h22};
        writeWords(7'h7F, 16);
        readWords(7'h7F, 16);
        readWords(7'h00, 8);

        $display("[TB] randomised write/read pairs");
        for (int r = 0; r < 8; r++) begin
            ra    = 7'($urandom_range(0, 127));
            rbits = ($urandom_range(0, 1) == 0) ? 8 : 16;
            tx_words = '{8'($urandom), 8'($urandom)};
            writeWords(ra, rbits);
            readWords(ra, rbits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
